commit_perf_monitor: RTL
========================

Name: commit_perf_monitor

Overview:
- Hardware performance and end-of-test monitor that consumes the ROB's two commit/writeback ports, the decode flush pulse and the decoder WFI flags.
- Counts cycles, committed instructions, committed branches, mispredict flushes and WFI cycles while a run is active.
- Detects test completion (a0 equals a sentinel value) and a commit-starvation timeout.
- Exposes all counters through a registered read port, so benches and the debug path no longer need hierarchical probes.

Parameters:
- CYC_W, 64, width of the cycle counter.
- EV_W, 32, width of each event counter (commit, branch, mispredict, wfi).
- DONE_VALUE, 32'hFFFF_FFFF, a0 value that signals test pass.
- WDOG_CYCLES, 100000, consecutive commit-free RUN cycles that trigger timeout; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  pulse; clears all counters and enters RUN
- c1_valid_i  in  1  commit port 1 valid_commit
- c1_flushed_i  in  1  commit port 1 flushed
- c1_is_branch_i  in  1  commit port 1 is_branch
- c2_valid_i  in  1  commit port 2 valid_commit
- c2_flushed_i  in  1  commit port 2 flushed
- c2_is_branch_i  in  1  commit port 2 is_branch
- must_flush_i  in  1  decode mispredict flush pulse
- wfi_a_i  in  1  decoder A WFI
- wfi_b_i  in  1  decoder B WFI
- a0_i  in  32  architectural x10 value
- rd_en_i  in  1  read request
- rd_addr_i  in  3  counter select
- rd_data_o  out  64  read data
- rd_valid_o  out  1  read data valid
- state_o  out  2  FSM state
- done_o  out  1  level; high in DONE
- timeout_o  out  1  level; high in TIMEOUT

Behaviour:
- Reset: every counter is 0, state is IDLE, and all outputs are 0.
- States: IDLE=0, RUN=1, DONE=2, TIMEOUT=3.
- Transitions:
  - start_i in any state → RUN next cycle. All counters and the watchdog are cleared on that edge; the start cycle itself counts nothing.
  - RUN with a0_i==DONE_VALUE → DONE.
  - RUN with watchdog==WDOG_CYCLES-1 and no effective commit → TIMEOUT.
  - If both the done and timeout conditions hold in the same cycle, DONE wins.
  - DONE and TIMEOUT hold until start_i or reset.
- Effective commit: eK = cK_valid_i & ~cK_flushed_i.
- Per RUN cycle, including the cycle that transitions out:
  - cycle += 1
  - commit += e1+e2 (0, 1 or 2)
  - branch += (e1&c1_is_branch_i)+(e2&c2_is_branch_i)
  - mispredict += must_flush_i
  - wfi += (wfi_a_i|wfi_b_i)
- Counters freeze outside RUN.
- All counters saturate at all-ones. They never wrap, including on a +2 step from max-1, which lands at max.
- Watchdog:
  - Clears on any effective commit or on start.
  - Otherwise increments in RUN.
- Read port:
  - rd_en_i at edge t → rd_data_o/rd_valid_o at t+1, with rd_valid_o high for exactly one cycle per request. Back-to-back reads are allowed.
  - Data is the counter value before the update at edge t.
  - Address map:
    - 0: cycle.
    - 1: commit, zero-extended.
    - 2: branch.
    - 3: mispredict.
    - 4: wfi.
    - 5: status word {60'b0, timeout, done, state}.
    - 6 and 7: return 0.
  - rd_data_o holds its last value when rd_valid_o is 0.
- Reset mid-run aborts immediately to IDLE with counters at 0.

Optional Feature:
- Macro: PERF_OVF_IRQ_EN.
- When defined:
  - Adds output ovf_irq_o (1 bit), a one-cycle pulse the cycle after any counter first reaches saturation.
  - Adds sticky status bit 4 at address 5, cleared by start_i.
- When not defined: no port and no logic are generated; bit 4 reads 0.

Decomposition:
- Shared package perf_pkg:
  - perf_state_e enum.
  - Address localparams PERF_ADDR_CYCLE through PERF_ADDR_STATUS.
  - commit_port_t struct {valid, flushed, is_branch}.
- One sub-module, perf_sat_counter:
  - Parameter W; inputs clr, en, inc[1:0].
  - Saturating; outputs count and a sat flag.
  - Instantiated five times.

Test Plan:
- start, 10 RUN cycles with both ports valid and unflushed, c1 branch each cycle, then a0=FFFF_FFFF → DONE; reads give cycle=11, commit=22, branch=11, status=6.
- Port 1 valid+flushed, port 2 valid, is_branch on both, for 5 cycles → commit=5, branch=5; must_flush pulsed 3 times → mispredict=3.
- WDOG_CYCLES=8 with no commits after start → timeout_o rises 8 cycles after entering RUN; a single commit at cycle 5 restarts the count.
- Force the commit counter to 32'hFFFF_FFFE (EV_W=32 via preload) then a double commit → reads FFFF_FFFF and stays there; with PERF_OVF_IRQ_EN, ovf_irq_o pulses once.
- Read addr 1 in the same cycle as a double commit → returns the old value; a read the next cycle → old+2. Address 6 → 0.
- Assert rst_n low mid-RUN → state_o=0 and all reads return 0; start_i in DONE → counters clear and RUN resumes.

Source files
------------

// File: rtl/commit_perf_monitor_pkg.sv
// perf_pkg: shared types and constants for the commit/perf monitor.
//   perf_state_e   - monitor FSM state encoding (IDLE=0, RUN=1, DONE=2, TIMEOUT=3)
//   PERF_ADDR_*    - read-port counter select addresses
//   commit_port_t  - one ROB commit/writeback port {valid, flushed, is_branch}
//   eff_commit()   - a commit counts only when valid and not flushed
package perf_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE    = 2'd0,
    PERF_RUN     = 2'd1,
    PERF_DONE    = 2'd2,
    PERF_TIMEOUT = 2'd3
  } perf_state_e;

  localparam logic [2:0] PERF_ADDR_CYCLE  = 3'd0;
  localparam logic [2:0] PERF_ADDR_COMMIT = 3'd1;
  localparam logic [2:0] PERF_ADDR_BRANCH = 3'd2;
  localparam logic [2:0] PERF_ADDR_MISP   = 3'd3;
  localparam logic [2:0] PERF_ADDR_WFI    = 3'd4;
  localparam logic [2:0] PERF_ADDR_STATUS = 3'd5;

  typedef struct packed {
    logic valid;
    logic flushed;
    logic is_branch;
  } commit_port_t;

  function automatic logic eff_commit(input commit_port_t p);
    return p.valid & ~p.flushed;
  endfunction

endpackage

// File: rtl/commit_perf_monitor_sat_counter.sv
// perf_sat_counter: W-bit counter that adds 0..3 per enabled cycle and sticks
// at all-ones instead of wrapping.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear (wins over en)
//   en         - apply inc this cycle
//   inc[1:0]   - increment amount
//   count      - current value
//   sat        - count is all-ones
module perf_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] r_count;
  logic [W:0]   w_sum;

  // One extra bit catches the carry so a +2 from max-1 lands at max.
  assign w_sum = {1'b0, r_count} + (W+1)'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_sum[W] ? '1 : w_sum[W-1:0];
    end
  end

  assign count = r_count;
  assign sat   = &r_count;

endmodule

// File: rtl/commit_perf_monitor.sv
// commit_perf_monitor: performance counters and end-of-test detection fed by
// the two ROB commit ports, the decode mispredict flush and the WFI flags.
//   clk, rst_n                   - clock, asynchronous active-low reset
//   start_i                      - clear all counters and enter RUN
//   c1_*/c2_*                    - commit ports {valid, flushed, is_branch}
//   must_flush_i                 - mispredict flush pulse
//   wfi_a_i, wfi_b_i             - decoder WFI flags
//   a0_i                         - x10; DONE_VALUE ends the test
//   rd_en_i, rd_addr_i           - counter read request (data one cycle later)
//   rd_data_o, rd_valid_o        - read response
//   state_o, done_o, timeout_o   - FSM state and terminal-state levels
// Optional macro PERF_OVF_IRQ_EN adds ovf_irq_o and sticky status bit 4.
module commit_perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned CYC_W       = 64,
  parameter int unsigned EV_W        = 32,
  parameter logic [31:0] DONE_VALUE  = 32'hFFFF_FFFF,
  parameter int unsigned WDOG_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        c1_valid_i,
  input  logic        c1_flushed_i,
  input  logic        c1_is_branch_i,
  input  logic        c2_valid_i,
  input  logic        c2_flushed_i,
  input  logic        c2_is_branch_i,
  input  logic        must_flush_i,
  input  logic        wfi_a_i,
  input  logic        wfi_b_i,
  input  logic [31:0] a0_i,
  input  logic        rd_en_i,
  input  logic [2:0]  rd_addr_i,
  output logic [63:0] rd_data_o,
  output logic        rd_valid_o,
  output logic [1:0]  state_o,
`ifdef PERF_OVF_IRQ_EN
  output logic        ovf_irq_o,
`endif
  output logic        done_o,
  output logic        timeout_o
);

  localparam int unsigned WD_W = $clog2(WDOG_CYCLES);

  perf_state_e  r_state, w_state_nxt;
  commit_port_t w_c1, w_c2;
  logic         w_e1, w_e2, w_any_commit, w_cnt_en, w_wdog_hit;
  logic [1:0]   w_inc_commit, w_inc_branch;
  logic [WD_W-1:0] r_wdog;
  logic [CYC_W-1:0] w_cycle;
  logic [EV_W-1:0]  w_commit, w_branch, w_misp, w_wfi;
  logic [4:0]   w_sat;
  logic         w_ovf_bit;
  logic [63:0]  w_status, w_rd_mux, r_rd_data;
  logic         r_rd_valid;

  assign w_c1         = {c1_valid_i, c1_flushed_i, c1_is_branch_i};
  assign w_c2         = {c2_valid_i, c2_flushed_i, c2_is_branch_i};
  assign w_e1         = eff_commit(w_c1);
  assign w_e2         = eff_commit(w_c2);
  assign w_any_commit = w_e1 | w_e2;
  assign w_inc_commit = {1'b0, w_e1} + {1'b0, w_e2};
  assign w_inc_branch = {1'b0, w_e1 & w_c1.is_branch} + {1'b0, w_e2 & w_c2.is_branch};
  // The start cycle counts nothing even when issued from RUN.
  assign w_cnt_en     = (r_state == PERF_RUN) & ~start_i;
  assign w_wdog_hit   = (r_wdog == WD_W'(WDOG_CYCLES - 1)) & ~w_any_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PERF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start_i) begin
      w_state_nxt = PERF_RUN;
    end else if (r_state == PERF_RUN) begin
      if (a0_i == DONE_VALUE) begin
        w_state_nxt = PERF_DONE;
      end else if (w_wdog_hit) begin
        w_state_nxt = PERF_TIMEOUT;
      end
    end
  end

  // Holds at the limit so a power-of-two WDOG_CYCLES cannot wrap to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (start_i) begin
      r_wdog <= '0;
    end else if (r_state == PERF_RUN) begin
      if (w_any_commit) begin
        r_wdog <= '0;
      end else if (!w_wdog_hit) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  perf_sat_counter #(.W(CYC_W)) u_cnt_cycle (
    .clk(clk), .rst_n(rst_n), .clr(start_i), .en(w_cnt_en),
    .inc(2'd1), .count(w_cycle), .sat(w_sat[0])
  );
  perf_sat_counter #(.W(EV_W)) u_cnt_commit (
    .clk(clk), .rst_n(rst_n), .clr(start_i), .en(w_cnt_en),
    .inc(w_inc_commit), .count(w_commit), .sat(w_sat[1])
  );
  perf_sat_counter #(.W(EV_W)) u_cnt_branch (
    .clk(clk), .rst_n(rst_n), .clr(start_i), .en(w_cnt_en),
    .inc(w_inc_branch), .count(w_branch), .sat(w_sat[2])
  );
  perf_sat_counter #(.W(EV_W)) u_cnt_misp (
    .clk(clk), .rst_n(rst_n), .clr(start_i), .en(w_cnt_en),
    .inc({1'b0, must_flush_i}), .count(w_misp), .sat(w_sat[3])
  );
  perf_sat_counter #(.W(EV_W)) u_cnt_wfi (
    .clk(clk), .rst_n(rst_n), .clr(start_i), .en(w_cnt_en),
    .inc({1'b0, wfi_a_i | wfi_b_i}), .count(w_wfi), .sat(w_sat[4])
  );

`ifdef PERF_OVF_IRQ_EN
  logic [4:0] r_sat_q;
  logic [4:0] w_sat_new;
  logic       r_ovf_sticky;

  // Rising edge of any sat flag: high in the cycle right after the counter
  // first hits all-ones.
  assign w_sat_new = w_sat & ~r_sat_q;
  assign ovf_irq_o = |w_sat_new;
  assign w_ovf_bit = r_ovf_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_q      <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_sat_q <= w_sat;
      if (start_i) begin
        r_ovf_sticky <= 1'b0;
      end else if (|w_sat_new) begin
        r_ovf_sticky <= 1'b1;
      end
    end
  end
`else
  logic w_unused_sat;
  assign w_unused_sat = &{1'b0, w_sat};
  assign w_ovf_bit    = 1'b0;
`endif

  assign state_o   = r_state;
  assign done_o    = (r_state == PERF_DONE);
  assign timeout_o = (r_state == PERF_TIMEOUT);
  assign w_status  = {59'b0, w_ovf_bit, timeout_o, done_o, state_o};

  always_comb begin
    w_rd_mux = '0;
    case (rd_addr_i)
      PERF_ADDR_CYCLE:  w_rd_mux = 64'(w_cycle);
      PERF_ADDR_COMMIT: w_rd_mux = 64'(w_commit);
      PERF_ADDR_BRANCH: w_rd_mux = 64'(w_branch);
      PERF_ADDR_MISP:   w_rd_mux = 64'(w_misp);
      PERF_ADDR_WFI:    w_rd_mux = 64'(w_wfi);
      PERF_ADDR_STATUS: w_rd_mux = w_status;
      default:          w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en_i;
      if (rd_en_i) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;

endmodule
